bmp_mstr_byte_sink: RTL

BMP_MSTR_BYTE_SINK -- requirements
Module: bmp_mstr_byte_sink

---
 rtl/bmp_mstr_byte_sink.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bmp_mstr_byte_sink.sv
// bmp_mstr_byte_sink: takes words from the arbiter master port into a 2-entry
// word buffer and serializes each word LSB byte first onto a byte handshake.
// A completion pulse from the master produces a one-cycle frame_done once
// everything buffered has drained.
// Optional feature: define BMP_MSTR_BYTECNT_EN to enable the frame byte counter
// on frame_bytes; otherwise frame_bytes is tied to zero.
module bmp_mstr_byte_sink #(
    parameter int DATA_BUS_SIZE = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_BUS_SIZE-1:0] data_to_master,
    input  logic [1:0]               mstr0_data_valid,
    input  logic                     mstr0_cmplt,
    output logic                     mstr0_ready,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     frame_done,
    output logic [23:0]              frame_bytes
);

    localparam int BPW   = DATA_BUS_SIZE / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_BUS_SIZE-1:0] buf_mem [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic                     ready_en;
    logic [DATA_BUS_SIZE-1:0] shift_reg;
    logic [IDX_W-1:0]         index;
    logic                     cmplt_pending;
    logic                     push;
    logic                     pop;
    logic                     byte_fire;
    logic                     unused_valid_bit;

    // bit1 of the valid field is reserved and deliberately ignored
    assign unused_valid_bit = mstr0_data_valid[1];

    // ready_en keeps mstr0_ready low during reset and lets it rise on the first edge after release
    assign mstr0_ready = ready_en & (count < 2'd2);
    assign push        = mstr0_data_valid[0] & mstr0_ready;
    assign byte_valid  = (state == SHIFT);
    assign byte_fire   = byte_valid & byte_ready;
    assign frame_done  = (state == DONE);

    // Select the current byte of the shift register; zero whenever no byte is offered
    always_comb begin
        byte_out = 8'h00;
        if (state == SHIFT) begin
            byte_out = shift_reg[8*int'(index) +: 8];
        end
    end

    // Next-state logic; a pending completion only wins once the buffer is empty
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end else if (cmplt_pending) begin
                    state_next = DONE;
                end
            end
            SHIFT: begin
                if (byte_fire && (index == LAST_IDX)) begin
                    if (count != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word buffer storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= data_to_master;
        end
    end

    // Word buffer pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Shift register load on pop, byte index advance on each accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            index     <= '0;
        end else if (pop) begin
            shift_reg <= buf_mem[rd_ptr];
            index     <= '0;
        end else if (byte_fire) begin
            index <= index + 1'b1;
        end
    end

    // Completion flag; a pulse landing in DONE is kept for the following frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmplt_pending <= 1'b0;
        end else if (mstr0_cmplt) begin
            cmplt_pending <= 1'b1;
        end else if (state == DONE) begin
            cmplt_pending <= 1'b0;
        end
    end

`ifdef BMP_MSTR_BYTECNT_EN
    logic [23:0] byte_cnt;
    logic        clear_next;

    // Frame byte counter: holds through DONE, restarts on the first byte of the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 24'd0;
            clear_next <= 1'b0;
        end else if (state == DONE) begin
            clear_next <= 1'b1;
        end else if (byte_fire) begin
            if (clear_next) begin
                byte_cnt   <= 24'd1;
                clear_next <= 1'b0;
            end else if (byte_cnt != 24'hFFFFFF) begin
                byte_cnt <= byte_cnt + 24'd1;
            end
        end
    end

    assign frame_bytes = byte_cnt;
`else
    assign frame_bytes = 24'd0;
`endif

endmodule
